// File: rtl/sparam_pkg.sv
// Shared types and helpers for the S-parameter ratio engine.
// Lane widths here are the engine defaults; the top-level width parameters default to them.
package sparam_pkg;

    localparam int unsigned DEF_MAG_W  = 16;
    localparam int unsigned DEF_PH_W   = 16;
    localparam int unsigned DEF_FRAC_W = 8;
    localparam int unsigned DEF_QW     = DEF_MAG_W + DEF_FRAC_W;

    // One polar lane: phase in the upper bits, magnitude in the lower bits.
    typedef struct packed {
        logic [DEF_PH_W-1:0]  ph;
        logic [DEF_MAG_W-1:0] mag;
    } lane_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDiv,
        StOut
    } state_e;

    // Phase is a fraction of a turn, so plain modular subtraction is the correct wrap.
    function automatic logic [DEF_PH_W-1:0] phase_sub(input logic [DEF_PH_W-1:0] b_ph,
                                                      input logic [DEF_PH_W-1:0] a_ph);
        return b_ph - a_ph;
    endfunction

    // Clamp a QW-bit quotient to the MAG_W-bit output magnitude.
    function automatic logic [DEF_MAG_W-1:0] saturate(input logic [DEF_QW-1:0] q);
        logic [DEF_MAG_W-1:0] r;
        if (|q[DEF_QW-1:DEF_MAG_W]) begin
            r = '1;
        end else begin
            r = q[DEF_MAG_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sparam_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, start/done handshake.
// A zero divisor skips the iteration and reports done on the following cycle with divzero_o set.
module sparam_serial_div #(
    parameter int unsigned QW    = 24,
    parameter int unsigned MAG_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [QW-1:0]    dividend_i,
    input  logic [MAG_W-1:0] divisor_i,
    output logic             done_o,
    output logic [QW-1:0]    quot_o,
    output logic             divzero_o
);

    localparam int unsigned CNT_W = $clog2(QW + 1);

    logic [QW-1:0]    quot_q;
    logic [MAG_W-1:0] rem_q;
    logic [MAG_W-1:0] den_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    logic [MAG_W:0]   shifted;
    logic [MAG_W:0]   trial;

    // Trial subtraction of the divisor from the partial remainder with the next dividend bit.
    always_comb begin
        shifted = {rem_q, quot_q[QW-1]};
        trial   = shifted - {1'b0, den_q};
    end

    // Iteration state; done is a one-cycle pulse one cycle after the last quotient bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quot_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                if (divisor_i == '0) begin
                    dz_q   <= 1'b1;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    quot_q <= '0;
                end else begin
                    dz_q   <= 1'b0;
                    rem_q  <= '0;
                    quot_q <= dividend_i;
                    den_q  <= divisor_i;
                    cnt_q  <= CNT_W'(QW);
                    busy_q <= 1'b1;
                end
            end else if (busy_q) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // No borrow means the divisor fits: keep the difference, quotient bit 1.
                    if (!trial[MAG_W]) begin
                        rem_q  <= trial[MAG_W-1:0];
                        quot_q <= {quot_q[QW-2:0], 1'b1};
                    end else begin
                        rem_q  <= shifted[MAG_W-1:0];
                        quot_q <= {quot_q[QW-2:0], 1'b0};
                    end
                end else begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign done_o    = done_q;
    assign quot_o    = quot_q;
    assign divzero_o = dz_q;

endmodule

// File: rtl/sparam_ratio_engine.sv
// S-parameter ratio engine: joins one a-beat and one b-beat, then emits every S_ji = b_j / a_i
// in ascending k = j*NPORTS + i order through a shared serial divider.
// Optional feature macro: SPARAM_DIVZERO_FLAG_EN adds a divide-by-zero MSB to m00_axis_tuser and a
// sticky divzero_seen_o output.
module sparam_ratio_engine
    import sparam_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned MAG_W  = DEF_MAG_W,
    parameter int unsigned PH_W   = DEF_PH_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    localparam int unsigned LANE_W = PH_W + MAG_W,
    localparam int unsigned IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1,
    localparam int unsigned QW     = MAG_W + FRAC_W,
`ifdef SPARAM_DIVZERO_FLAG_EN
    localparam int unsigned TUSER_W = 2 * IDX_W + 1
`else
    localparam int unsigned TUSER_W = 2 * IDX_W
`endif
) (
    input  logic                     s00_axis_aclk,
    input  logic                     s00_axis_aresetn,
    input  logic [NPORTS*LANE_W-1:0] s00_axis_tdata,
    input  logic                     s00_axis_tvalid,
    input  logic                     s00_axis_tlast,
    output logic                     s00_axis_tready,
    input  logic [NPORTS*LANE_W-1:0] s01_axis_tdata,
    input  logic                     s01_axis_tvalid,
    output logic                     s01_axis_tready,
    output logic [LANE_W-1:0]        m00_axis_tdata,
    output logic [TUSER_W-1:0]       m00_axis_tuser,
    output logic                     m00_axis_tvalid,
    output logic                     m00_axis_tlast,
    input  logic                     m00_axis_tready
`ifdef SPARAM_DIVZERO_FLAG_EN
    ,
    output logic                     divzero_seen_o
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPORTS - 1);

    state_e            state_q;
    lane_t             a_q [NPORTS];
    lane_t             b_q [NPORTS];
    logic              last_q;
    // j_q/i_q together form k = j*NPORTS + i; keeping them split avoids a divide by NPORTS.
    logic [IDX_W-1:0]  j_q;
    logic [IDX_W-1:0]  i_q;
    logic [LANE_W-1:0] tdata_q;
    logic [TUSER_W-1:0] tuser_q;
    logic              tvalid_q;
    logic              tlast_q;
`ifdef SPARAM_DIVZERO_FLAG_EN
    logic              divzero_seen_q;
`endif

    logic              join_fire;
    logic              last_elem;
    logic              div_start;
    logic              div_done;
    logic              div_dz;
    logic [QW-1:0]     div_quot;
    logic [QW-1:0]     dividend;
    lane_t             a_sel;
    lane_t             b_sel;
    lane_t             result;

    // Both streams move together, only from IDLE; the reset gate keeps tready low while in reset.
    assign join_fire       = (state_q == StIdle) & s00_axis_tvalid & s01_axis_tvalid
                             & s00_axis_aresetn;
    assign s00_axis_tready = join_fire;
    assign s01_axis_tready = join_fire;

    assign last_elem = (j_q == LAST_IDX) && (i_q == LAST_IDX);
    assign a_sel     = a_q[i_q];
    assign b_sel     = b_q[j_q];
    assign dividend  = {b_sel.mag, {FRAC_W{1'b0}}};
    assign div_start = (state_q == StLoad);

    sparam_serial_div #(
        .QW    (QW),
        .MAG_W (MAG_W)
    ) u_div (
        .clk_i      (s00_axis_aclk),
        .rst_ni     (s00_axis_aresetn),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (a_sel.mag),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .divzero_o  (div_dz)
    );

    // Element value: zero divisor forces full-scale magnitude and zero phase.
    always_comb begin
        result = '0;
        if (div_dz) begin
            result.ph  = '0;
            result.mag = '1;
        end else begin
            result.ph  = phase_sub(b_sel.ph, a_sel.ph);
            result.mag = saturate(div_quot);
        end
    end

    // Control FSM with lane latch, element index and registered m00 outputs.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q  <= StIdle;
            last_q   <= 1'b0;
            j_q      <= '0;
            i_q      <= '0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            for (int p = 0; p < NPORTS; p++) begin
                a_q[p] <= '0;
                b_q[p] <= '0;
            end
`ifdef SPARAM_DIVZERO_FLAG_EN
            divzero_seen_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (join_fire) begin
                        for (int p = 0; p < NPORTS; p++) begin
                            a_q[p] <= s00_axis_tdata[p*LANE_W +: LANE_W];
                            b_q[p] <= s01_axis_tdata[p*LANE_W +: LANE_W];
                        end
                        last_q  <= s00_axis_tlast;
                        j_q     <= '0;
                        i_q     <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    state_q <= StDiv;
                end
                StDiv: begin
                    if (div_done) begin
                        tdata_q  <= result;
`ifdef SPARAM_DIVZERO_FLAG_EN
                        tuser_q  <= {div_dz, j_q, i_q};
                        if (div_dz) begin
                            divzero_seen_q <= 1'b1;
                        end
`else
                        tuser_q  <= {j_q, i_q};
`endif
                        tvalid_q <= 1'b1;
                        tlast_q  <= last_q & last_elem;
                        state_q  <= StOut;
                    end
                end
                StOut: begin
                    if (m00_axis_tready) begin
                        tvalid_q <= 1'b0;
                        if (last_elem) begin
                            state_q <= StIdle;
                        end else begin
                            if (i_q == LAST_IDX) begin
                                i_q <= '0;
                                j_q <= j_q + IDX_W'(1);
                            end else begin
                                i_q <= i_q + IDX_W'(1);
                            end
                            state_q <= StLoad;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tuser  = tuser_q;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
`ifdef SPARAM_DIVZERO_FLAG_EN
    assign divzero_seen_o  = divzero_seen_q;
`endif

endmodule

// File: tb/tb_sparam_ratio_engine.sv
// Directed bench for sparam_ratio_engine (NPORTS=2, MAG_W=PH_W=16, FRAC_W=8).
module tb_sparam_ratio_engine;

    localparam int LW = 32;
    localparam int DW = 64;
`ifdef SPARAM_DIVZERO_FLAG_EN
    localparam int UW = 3;
`else
    localparam int UW = 2;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic          a_valid = 1'b0;
    logic          b_valid = 1'b0;
    logic          a_last = 1'b0;
    logic          a_ready;
    logic          b_ready;
    logic [LW-1:0] m_data;
    logic [UW-1:0] m_user;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b1;
`ifdef SPARAM_DIVZERO_FLAG_EN
    logic          dz_seen;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sparam_ratio_engine #(
        .NPORTS (2),
        .MAG_W  (16),
        .PH_W   (16),
        .FRAC_W (8)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rstn),
        .s00_axis_tdata   (a_data),
        .s00_axis_tvalid  (a_valid),
        .s00_axis_tlast   (a_last),
        .s00_axis_tready  (a_ready),
        .s01_axis_tdata   (b_data),
        .s01_axis_tvalid  (b_valid),
        .s01_axis_tready  (b_ready),
        .m00_axis_tdata   (m_data),
        .m00_axis_tuser   (m_user),
        .m00_axis_tvalid  (m_valid),
        .m00_axis_tlast   (m_last),
        .m00_axis_tready  (m_ready)
`ifdef SPARAM_DIVZERO_FLAG_EN
        ,
        .divzero_seen_o   (dz_seen)
`endif
    );

    function automatic logic [LW-1:0] ln(input logic [15:0] ph, input logic [15:0] mag);
        return {ph, mag};
    endfunction

    // Expected tuser: {dz, j, i}; the dz bit drops out when the flag build is off.
    function automatic logic [UW-1:0] exp_user(input int j, input int i, input logic dz);
        logic [2:0] u;
        u = {dz, j[0], i[0]};
        return u[UW-1:0];
    endfunction

    // Present one joined beat from a negedge; returns at the negedge after the handshake edge.
    task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last,
                             output int hs);
        int n;
        a_data = a; b_data = b; a_last = last; a_valid = 1'b1; b_valid = 1'b1;
        n = 0;
        #1;
        while (!(a_ready && b_ready) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL join_timeout: tready got %b%b required 11", a_ready, b_ready);
        end
        @(negedge clk);
        hs = cyc;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    // Wait (bounded) for an element and accept it with m_ready held high.
    task automatic get_elem(output logic [LW-1:0] d, output logic [UW-1:0] u, output logic l,
                            output int v);
        int n;
        n = 0;
        while (m_valid !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL elem_timeout: tvalid got %b required 1", m_valid);
        end
        d = m_data; u = m_user; l = m_last; v = cyc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_s00_tready: got %b required 0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_s01_tready: got %b required 0", b_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b required 0", m_last); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_tdata: got %h required 0", m_data); end
        checks++; if (m_user !== '0) begin errors++; $display("FAIL rst_tuser: got %h required 0", m_user); end
`ifdef SPARAM_DIVZERO_FLAG_EN
        checks++; if (dz_seen !== 1'b0) begin errors++; $display("FAIL rst_dz_seen: got %b required 0", dz_seen); end
`endif
        a_valid = 1'b0; b_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [LW-1:0] ed [4];
        logic [LW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
        int            hs, v, pv;
        ed = '{32'h2000_0200, 32'h3100_0100, 32'hF100_0400, 32'h0200_0200};
        send_beat({ln(16'hFF00, 16'h0080), ln(16'h1000, 16'h0040)},
                  {ln(16'h0100, 16'h0100), ln(16'h3000, 16'h0080)}, 1'b1, hs);
        pv = 0;
        for (int k = 0; k < 4; k++) begin
            get_elem(d, u, l, v);
            checks++; if (d !== ed[k]) begin errors++; $display("FAIL basic_data[%0d]: got %h required %h", k, d, ed[k]); end
            checks++; if (u !== exp_user(k / 2, k % 2, 1'b0)) begin errors++; $display("FAIL basic_user[%0d]: got %b required %b", k, u, exp_user(k / 2, k % 2, 1'b0)); end
            checks++; if (l !== (k == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %b required %b", k, l, (k == 3)); end
            // Handshake edge is the edge after tvalid rose, since m_ready is held high.
            checks++;
            if ((v - ((k == 0) ? hs : pv + 1)) != 27) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d required 27", k, v - ((k == 0) ? hs : pv + 1));
            end
            pv = v;
        end
    endtask

    task automatic test_divzero();
        logic [LW-1:0] ed [4];
        logic          edz [4];
        int            elat [4];
        logic [LW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
        int            hs, v, pv;
        ed   = '{32'h0500_0100, 32'h0000_FFFF, 32'h0700_0300, 32'h0000_FFFF};
        edz  = '{1'b0, 1'b1, 1'b0, 1'b1};
        elat = '{27, 2, 27, 2};
        send_beat({ln(16'h1234, 16'h0000), ln(16'h0000, 16'h0100)},
                  {ln(16'h0700, 16'h0300), ln(16'h0500, 16'h0100)}, 1'b0, hs);
        pv = 0;
        for (int k = 0; k < 4; k++) begin
            get_elem(d, u, l, v);
            checks++; if (d !== ed[k]) begin errors++; $display("FAIL dz_data[%0d]: got %h required %h", k, d, ed[k]); end
            checks++; if (u !== exp_user(k / 2, k % 2, edz[k])) begin errors++; $display("FAIL dz_user[%0d]: got %b required %b", k, u, exp_user(k / 2, k % 2, edz[k])); end
            checks++; if (l !== 1'b0) begin errors++; $display("FAIL dz_last[%0d]: got %b required 0", k, l); end
            checks++;
            if ((v - ((k == 0) ? hs : pv + 1)) != elat[k]) begin
                errors++;
                $display("FAIL dz_latency[%0d]: got %0d required %0d", k, v - ((k == 0) ? hs : pv + 1), elat[k]);
            end
            pv = v;
        end
`ifdef SPARAM_DIVZERO_FLAG_EN
        checks++; if (dz_seen !== 1'b1) begin errors++; $display("FAIL dz_seen: got %b required 1", dz_seen); end
`endif
    endtask

    task automatic test_saturate();
        logic [LW-1:0] ed [4];
        logic [LW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
        int            hs, v;
        ed = '{32'hFFFF_FFFF, 32'h7FFF_0100, 32'h8000_0100, 32'h0000_0000};
        send_beat({ln(16'h0000, 16'hFFFF), ln(16'h8000, 16'h0001)},
                  {ln(16'h0000, 16'h0001), ln(16'h7FFF, 16'hFFFF)}, 1'b1, hs);
        for (int k = 0; k < 4; k++) begin
            get_elem(d, u, l, v);
            checks++; if (d !== ed[k]) begin errors++; $display("FAIL sat_data[%0d]: got %h required %h", k, d, ed[k]); end
            checks++; if (u !== exp_user(k / 2, k % 2, 1'b0)) begin errors++; $display("FAIL sat_user[%0d]: got %b required %b", k, u, exp_user(k / 2, k % 2, 1'b0)); end
        end
    endtask

    task automatic test_join();
        logic seen;
        a_data = {ln(16'h1111, 16'h0010), ln(16'h2222, 16'h0020)};
        b_data = a_data;
        a_valid = 1'b1; b_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                errors++;
                $display("FAIL join_a_only[%0d]: tready got %b%b required 00", c, a_ready, b_ready);
            end
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                errors++;
                $display("FAIL join_b_only[%0d]: tready got %b%b required 00", c, a_ready, b_ready);
            end
            @(negedge clk);
        end
        b_valid = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL join_no_output: tvalid seen %b required 0", seen); end
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] ed [4];
        logic [LW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
        int            hs, v, n;
        ed = '{32'h2000_0200, 32'h3100_0100, 32'hF100_0400, 32'h0200_0200};
        m_ready = 1'b0;
        send_beat({ln(16'hFF00, 16'h0080), ln(16'h1000, 16'h0040)},
                  {ln(16'h0100, 16'h0100), ln(16'h3000, 16'h0080)}, 1'b1, hs);
        n = 0;
        while (m_valid !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL bp_timeout: tvalid got %b required 1", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL bp_last[0]: got %b required 0", m_last); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== ed[0] || m_user !== exp_user(0, 0, 1'b0)) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h u=%b required v=1 d=%h u=%b",
                         c, m_valid, m_data, m_user, ed[0], exp_user(0, 0, 1'b0));
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        for (int k = 1; k < 4; k++) begin
            get_elem(d, u, l, v);
            checks++; if (d !== ed[k]) begin errors++; $display("FAIL bp_data[%0d]: got %h required %h", k, d, ed[k]); end
            checks++; if (u !== exp_user(k / 2, k % 2, 1'b0)) begin errors++; $display("FAIL bp_user[%0d]: got %b required %b", k, u, exp_user(k / 2, k % 2, 1'b0)); end
            checks++; if (l !== (k == 3)) begin errors++; $display("FAIL bp_last[%0d]: got %b required %b", k, l, (k == 3)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] ed [4];
        logic [LW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
        logic          seen;
        int            hs, v;
        ed = '{32'hFFFF_FFFF, 32'h7FFF_0100, 32'h8000_0100, 32'h0000_0000};
        send_beat({ln(16'hFF00, 16'h0080), ln(16'h1000, 16'h0040)},
                  {ln(16'h0100, 16'h0100), ln(16'h3000, 16'h0080)}, 1'b1, hs);
        repeat (10) @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1;
        rstn = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b required 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL midrst_tdata: got %h required 0", m_data); end
        checks++; if (m_user !== '0) begin errors++; $display("FAIL midrst_tuser: got %b required 0", m_user); end
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL midrst_tready: got %b%b required 00", a_ready, b_ready); end
        repeat (2) @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rstn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_stale: tvalid seen %b required 0", seen); end
        send_beat({ln(16'h0000, 16'hFFFF), ln(16'h8000, 16'h0001)},
                  {ln(16'h0000, 16'h0001), ln(16'h7FFF, 16'hFFFF)}, 1'b1, hs);
        for (int k = 0; k < 4; k++) begin
            get_elem(d, u, l, v);
            checks++; if (d !== ed[k]) begin errors++; $display("FAIL midrst_data[%0d]: got %h required %h", k, d, ed[k]); end
            checks++; if (u !== exp_user(k / 2, k % 2, 1'b0)) begin errors++; $display("FAIL midrst_user[%0d]: got %b required %b", k, u, exp_user(k / 2, k % 2, 1'b0)); end
            checks++; if (l !== (k == 3)) begin errors++; $display("FAIL midrst_last[%0d]: got %b required %b", k, l, (k == 3)); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_divzero();
        test_saturate();
        test_join();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
